decoder_nx2n_seq: RTL
=====================

// Module: decoder_nx2n_seq
// PURPOSE
//   Parametrised, registered N-to-2^N one-hot decoder with enable. It replaces the
//   fixed 2x4 combinational decoder where select outputs must be glitch-free,
//   time-limited or auto-sequenced.
//   Three modes:
//     - DIRECT: registered decode.
//     - PULSE:  one-hot held for a fixed count.
//     - SCAN:   walks every output in turn.
//   Drives chip-select, row-strobe and LED-scan style loads.
// PARAMETERS
//   N          2   select width; output width is 2^N (N >= 1)
//   PULSE_LEN  4   cycles an output is held in PULSE mode (>= 1)
//   DWELL      1   cycles each output is held in SCAN mode (>= 1)
//   WRAP       0   SCAN: 0 = stop after last output; 1 = restart at 0 until en drops
// PORTS
//   clk   in   1      single clock, rising edge
//   rst   in   1      asynchronous, active-high reset
//   en    in   1      global enable; low forces outputs off
//   mode  in   2      00 DIRECT, 01 PULSE, 10 SCAN, 11 reserved
//   sel   in   N      index to decode (DIRECT/PULSE)
//   load  in   1      start strobe for PULSE/SCAN, sampled in IDLE only
//   q     out  2^N    registered one-hot (or all-zero) output
//   idx   out  N      index currently asserted on q (0 when q == 0)
//   busy  out  1      high while PULSE or SCAN in progress
//   done  out  1      one-cycle strobe at completion/wrap
// BEHAVIOUR
// Reset and state machine
//   - Reset (async, any time):
//       q = 0, idx = 0, busy = 0, done = 0, state = IDLE, counters = 0.
//   - States: IDLE, PULSE, SCAN. busy = (state != IDLE).
//   - mode is latched at load; mode changes while busy are ignored.
// IDLE
//   - mode 00: q <= en ? (1 << sel) : 0, and idx <= en ? sel : 0.
//     Latency 1 clk; load is ignored.
//   - mode 11: q <= 0, idx <= 0; load is ignored.
//   - mode 01 with load & en: q <= 1 << sel, idx <= sel, cnt <= PULSE_LEN-1 -> PULSE.
//   - mode 10 with load & en: q <= 1, idx <= 0, cnt <= DWELL-1 -> SCAN.
//   - load with en = 0: ignored, stays IDLE.
// PULSE
//   - Each clk: if cnt != 0, cnt--.
//   - When cnt == 0: q <= 0, idx <= 0, done <= 1 -> IDLE.
//   - Result: q is high exactly PULSE_LEN cycles. load and sel are ignored.
// SCAN
//   - Each clk: if cnt != 0, cnt--.
//   - Else, when idx != 2^N-1: idx++, q <<= 1, cnt <= DWELL-1.
//   - Else (last output, dwell expired):
//       WRAP = 0: q <= 0, idx <= 0, done <= 1 -> IDLE.
//       WRAP = 1: q <= 1, idx <= 0, cnt <= DWELL-1, done <= 1, stay in SCAN.
// Abort and strobes
//   - en low in PULSE or SCAN: next edge q <= 0, idx <= 0 -> IDLE.
//     No done strobe on abort.
//   - done is high exactly one cycle and is otherwise 0.
//   - done coincides with the edge that clears q or wraps it.
// Invariants
//   - q is never multi-hot.
//   - q is zero whenever en was low at the previous edge.
//   - Internal counter width: clog2(max(PULSE_LEN, DWELL)) + 1.
//   - All outputs are registered; there is no combinational path from input to output.
// TESTING  (N = 2, PULSE_LEN = 4, DWELL = 2 unless noted)
//   1. DIRECT, en = 1, sel = 0..3 on successive clks -> q = 1, 2, 4, 8, each one
//      clk later; en = 0 -> q = 0 next clk.
//   2. PULSE, sel = 2, load for 1 clk -> q = 4'b0100 for 4 clks, then 0.
//      done high on the clearing edge; busy high 4 clks; a second load mid-pulse
//      is ignored.
//   3. SCAN, WRAP = 0, load -> q = 1, 1, 2, 2, 4, 4, 8, 8, then 0.
//      idx follows q; done on the final edge.
//   4. SCAN, WRAP = 1 -> after 8 clks q returns to 1 with done = 1.
//      en = 0 at clk 11 -> q = 0 and IDLE next clk, with no done.
//   5. Assert rst mid-PULSE and mid-SCAN, asynchronously between edges ->
//      q, idx, busy and done go to 0 immediately; the first load after release
//      behaves as in test 2.
//   6. mode 11, or mode changed 01 -> 00 while busy -> q = 0 in IDLE.
//      The pulse in flight completes unchanged.

Source files
------------

// File: rtl/decoder_nx2n_seq.sv
// Registered N-to-2^N one-hot decoder with three modes: direct decode,
// fixed-length pulse, and an auto-sequenced scan across every output.
module decoder_nx2n_seq #(
    parameter int N         = 2,
    parameter int PULSE_LEN = 4,
    parameter int DWELL     = 1,
    parameter int WRAP      = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [N-1:0]      sel,
    input  logic              load,
    output logic [2**N-1:0]   q,
    output logic [N-1:0]      idx,
    output logic              busy,
    output logic              done
);

    localparam int Q    = 2**N;
    localparam int MAXC = (PULSE_LEN > DWELL) ? PULSE_LEN : DWELL;
    localparam int CW   = $clog2(MAXC) + 1;

    localparam logic [Q-1:0]  ONE       = Q'(1);
    localparam logic [N-1:0]  LAST      = '1;
    localparam logic [CW-1:0] PULSE_CNT = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] DWELL_CNT = CW'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        SCAN  = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [Q-1:0]  q_n;
    logic [N-1:0]  idx_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          done_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            q     <= '0;
            idx   <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            q     <= q_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
            done  <= done_n;
        end
    end

    // The mode that started an operation is implied by the state, so mode
    // changes while busy have no effect.
    always_comb begin
        state_n = state;
        q_n     = q;
        idx_n   = idx;
        cnt_n   = cnt;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                q_n   = '0;
                idx_n = '0;
                cnt_n = '0;
                if (en) begin
                    case (mode)
                        2'b00: begin
                            q_n   = ONE << sel;
                            idx_n = sel;
                        end
                        2'b01: begin
                            if (load) begin
                                q_n     = ONE << sel;
                                idx_n   = sel;
                                cnt_n   = PULSE_CNT;
                                state_n = PULSE;
                            end
                        end
                        2'b10: begin
                            if (load) begin
                                q_n     = ONE;
                                cnt_n   = DWELL_CNT;
                                state_n = SCAN;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            PULSE: begin
                if (!en) begin
                    q_n     = '0;
                    idx_n   = '0;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                end else begin
                    q_n     = '0;
                    idx_n   = '0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            SCAN: begin
                if (!en) begin
                    q_n     = '0;
                    idx_n   = '0;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                end else if (idx != LAST) begin
                    idx_n = idx + N'(1);
                    q_n   = q << 1;
                    cnt_n = DWELL_CNT;
                end else begin
                    done_n = 1'b1;
                    idx_n  = '0;
                    if (WRAP != 0) begin
                        q_n   = ONE;
                        cnt_n = DWELL_CNT;
                    end else begin
                        q_n     = '0;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                q_n     = '0;
                idx_n   = '0;
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule
